// File: rtl/rtc_bus_pkg.sv
// Shared types and constants for the RTC multiplexed address/data bus responder.
package rtc_bus_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int NREGS_DEF  = 16;

  // Strobe bundle order is {a_d, cs, rd, wr}; every line idles high.
  localparam logic [3:0] STROBE_IDLE = 4'b1111;

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    DATA_WR,
    DATA_RD
  } state_t;

endpackage

// File: rtl/rtc_strobe_sync.sv
// Per-bit delay chain for bus inputs: two flops with RTC_RESP_SYNC_EN defined, one otherwise.
module rtc_strobe_sync #(
  parameter int               WIDTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

`ifdef RTC_RESP_SYNC_EN
  localparam int DEPTH = 2;
`else
  localparam int DEPTH = 1;
`endif

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_bit
      logic [DEPTH-1:0] chain_reg;

      always_ff @(posedge clk) begin
        if (reset) begin
          chain_reg <= {DEPTH{RESET_VAL[gi]}};
        end else begin
          chain_reg[0] <= d[gi];
          for (int k = 1; k < DEPTH; k++) begin
            chain_reg[k] <= chain_reg[k-1];
          end
        end
      end

      assign q[gi] = chain_reg[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/rtc_bus_responder.sv
// Responder end of the multiplexed RTC address/data bus with an inline register bank and core side port.
// Define RTC_RESP_SYNC_EN to pass bus inputs through 2-flop synchronizers instead of a single register.
module rtc_bus_responder
  import rtc_bus_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int NREGS  = NREGS_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              a_d,
  input  logic              cs,
  input  logic              rd,
  input  logic              wr,
  input  logic [DATA_W-1:0] ad_in,
  output logic [DATA_W-1:0] ad_out,
  output logic              ad_oe,
  input  logic              core_we,
  input  logic [DATA_W-1:0] core_addr,
  input  logic [DATA_W-1:0] core_wdata,
  output logic              bus_we,
  output logic [DATA_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  output logic              addr_err
);

  localparam int AW = (NREGS > 1) ? $clog2(NREGS) : 1;

  logic [3:0]        strobe_s;
  logic [DATA_W-1:0] ad_s;
  logic              s_a_d, s_cs, s_rd, s_wr;

  // Data goes through the same delay as the strobes so both stay aligned.
  rtc_strobe_sync #(.WIDTH(4), .RESET_VAL(STROBE_IDLE)) u_strobe_sync (
    .clk   (clk),
    .reset (reset),
    .d     ({a_d, cs, rd, wr}),
    .q     (strobe_s)
  );

  rtc_strobe_sync #(.WIDTH(DATA_W), .RESET_VAL('0)) u_data_sync (
    .clk   (clk),
    .reset (reset),
    .d     (ad_in),
    .q     (ad_s)
  );

  assign {s_a_d, s_cs, s_rd, s_wr} = strobe_s;

  state_t            state_reg;
  logic [DATA_W-1:0] addr_shadow_reg, data_shadow_reg;
  logic [DATA_W-1:0] ad_out_reg, bus_addr_reg, bus_wdata_reg;
  logic              ad_oe_reg, bus_we_reg, addr_err_reg;
  logic [DATA_W-1:0] regs_reg [NREGS];

  logic              bus_in_range, core_in_range, wr_release, bus_commit;
  logic [DATA_W-1:0] rd_value;

  always_comb begin
    bus_in_range  = (32'(bus_addr_reg) < 32'(NREGS));
    core_in_range = (32'(core_addr) < 32'(NREGS));
    wr_release    = s_cs | s_wr;
    bus_commit    = (state_reg == DATA_WR) && wr_release && bus_in_range;
    rd_value      = '1;
    if (bus_in_range) begin
      rd_value = regs_reg[bus_addr_reg[AW-1:0]];
    end
  end

  // Bus commit has priority over a core write to the same register.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_reg[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        if (bus_commit && bus_addr_reg == DATA_W'(i)) begin
          regs_reg[i] <= data_shadow_reg;
        end else if (core_we && core_in_range && core_addr == DATA_W'(i)) begin
          regs_reg[i] <= core_wdata;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg       <= IDLE;
      addr_shadow_reg <= '0;
      data_shadow_reg <= '0;
      ad_out_reg      <= '0;
      ad_oe_reg       <= 1'b0;
      bus_we_reg      <= 1'b0;
      bus_addr_reg    <= '0;
      bus_wdata_reg   <= '0;
      addr_err_reg    <= 1'b0;
    end else begin
      bus_we_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          // Write strobe wins when rd and wr are both low in a data phase.
          if (!s_cs && !s_wr) begin
            if (!s_a_d) begin
              state_reg       <= ADDR;
              addr_shadow_reg <= ad_s;
            end else begin
              state_reg       <= DATA_WR;
              data_shadow_reg <= ad_s;
            end
          end else if (!s_cs && !s_rd && s_a_d) begin
            state_reg  <= DATA_RD;
            ad_oe_reg  <= 1'b1;
            ad_out_reg <= rd_value;
            if (!bus_in_range) begin
              addr_err_reg <= 1'b1;
            end
          end
        end
        ADDR: begin
          if (wr_release) begin
            bus_addr_reg <= addr_shadow_reg;
            state_reg    <= IDLE;
          end else begin
            addr_shadow_reg <= ad_s;
          end
        end
        DATA_WR: begin
          if (wr_release) begin
            bus_wdata_reg <= data_shadow_reg;
            bus_we_reg    <= bus_in_range;
            if (!bus_in_range) begin
              addr_err_reg <= 1'b1;
            end
            state_reg <= IDLE;
          end else begin
            data_shadow_reg <= ad_s;
          end
        end
        DATA_RD: begin
          if (s_cs || s_rd) begin
            ad_oe_reg <= 1'b0;
            state_reg <= IDLE;
          end else begin
            ad_out_reg <= rd_value;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign ad_out    = ad_out_reg;
  assign ad_oe     = ad_oe_reg;
  assign bus_we    = bus_we_reg;
  assign bus_addr  = bus_addr_reg;
  assign bus_wdata = bus_wdata_reg;
  assign addr_err  = addr_err_reg;

endmodule
